// File: rtl/led_display_scan_ctrl.sv
// HUB75 scan sequencer: fetch a row, shift it out, blank, latch, display.
// Rows are walked cyclically; fetcher address mismatches are flagged sticky.
module led_display_scan_ctrl #(
  parameter int ROWS         = 16,
  parameter int ROW_ADDR_W   = 4,
  parameter int COLS         = 64,
  parameter int BLANK_CYCLES = 4,
  parameter int ON_CYCLES    = 256
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic                  enable_in,
  output logic                  row_ready_out,
  input  logic                  row_valid_in,
  input  logic [ROW_ADDR_W-1:0] row_address_in,
  input  logic [6*COLS-1:0]     row_in,
  output logic                  hub_r0_out,
  output logic                  hub_g0_out,
  output logic                  hub_b0_out,
  output logic                  hub_r1_out,
  output logic                  hub_g1_out,
  output logic                  hub_b1_out,
  output logic                  hub_clk_out,
  output logic                  hub_lat_out,
  output logic                  hub_oe_n_out,
  output logic [ROW_ADDR_W-1:0] hub_addr_out,
  output logic                  frame_done_out,
  output logic                  addr_err_out
);

  typedef struct packed {
    logic [COLS-1:0] top_r;
    logic [COLS-1:0] top_g;
    logic [COLS-1:0] top_b;
    logic [COLS-1:0] bot_r;
    logic [COLS-1:0] bot_g;
    logic [COLS-1:0] bot_b;
  } rgb_row_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_e;

  localparam int SHIFT_LEN = 2 * COLS;
  localparam int MAX_A = (SHIFT_LEN > BLANK_CYCLES) ? SHIFT_LEN : BLANK_CYCLES;
  localparam int CNT_MAX = (MAX_A > ON_CYCLES) ? MAX_A : ON_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_CYCLES - 1);
  localparam logic [ROW_ADDR_W-1:0] ROW_LAST = ROW_ADDR_W'(ROWS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ROW_ADDR_W-1:0] row_q, row_d;
  rgb_row_t              buf_q, buf_d;
  logic                  err_q, err_d;
  logic [ROW_ADDR_W-1:0] addr_q, addr_d;
  logic                  fd_q, fd_d;
  logic                  ready_q, ready_d;
  logic                  hclk_q, hclk_d;
  logic                  lat_q, lat_d;
  logic                  oe_n_q, oe_n_d;
  logic [5:0]            data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    buf_d   = buf_q;
    err_d   = err_q;
    addr_d  = addr_q;
    fd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable_in) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        if (row_valid_in) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          buf_d   = row_in;
          if (row_address_in != row_q) err_d = 1'b1;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        // advance to the next column after its clock-high phase
        if (cnt_q[0]) begin
          buf_d.top_r = buf_q.top_r << 1;
          buf_d.top_g = buf_q.top_g << 1;
          buf_d.top_b = buf_q.top_b << 1;
          buf_d.bot_r = buf_q.bot_r << 1;
          buf_d.bot_g = buf_q.bot_g << 1;
          buf_d.bot_b = buf_q.bot_b << 1;
        end
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          addr_d  = row_q;
        end
      end
      S_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        cnt_d   = '0;
      end
      S_DISPLAY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          row_d   = row_q + 1'b1;
          fd_d    = (row_q == ROW_LAST);
          state_d = enable_in ? S_REQUEST : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // pin values are decoded from the next state so they line up with it
  always_comb begin
    ready_d = (state_d == S_REQUEST);
    hclk_d  = (state_d == S_SHIFT) && cnt_d[0];
    lat_d   = (state_d == S_LATCH);
    oe_n_d  = (state_d != S_DISPLAY);
    data_d  = '0;
    if (state_d == S_SHIFT) begin
      data_d = {buf_d.top_r[COLS-1], buf_d.top_g[COLS-1],
                buf_d.top_b[COLS-1], buf_d.bot_r[COLS-1],
                buf_d.bot_g[COLS-1], buf_d.bot_b[COLS-1]};
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      fd_q    <= 1'b0;
      ready_q <= 1'b0;
      hclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      fd_q    <= fd_d;
      ready_q <= ready_d;
      hclk_q  <= hclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      data_q  <= data_d;
    end
  end

  assign row_ready_out  = ready_q;
  assign hub_r0_out     = data_q[5];
  assign hub_g0_out     = data_q[4];
  assign hub_b0_out     = data_q[3];
  assign hub_r1_out     = data_q[2];
  assign hub_g1_out     = data_q[1];
  assign hub_b1_out     = data_q[0];
  assign hub_clk_out    = hclk_q;
  assign hub_lat_out    = lat_q;
  assign hub_oe_n_out   = oe_n_q;
  assign hub_addr_out   = addr_q;
  assign frame_done_out = fd_q;
  assign addr_err_out   = err_q;

endmodule

// File: doc/led_display_scan_ctrl.md
Name: led_display_scan_ctrl

Overview:
- Sequences HUB75-style panel refresh. For each scan row it requests row data from the RAM-side row fetcher using the row_ready/row_valid handshake.
- It shifts the captured row out serially, then blanks, latches and displays it for a fixed on-time.
- It walks rows 0..ROWS-1 cyclically and flags any row-address mismatch from the fetcher.
- Sits between the RAM row fetcher and the panel pins.

Parameters:
- ROWS, 16: scan rows per frame (power of two).
- ROW_ADDR_W, 4: width of row address, log2(ROWS).
- COLS, 64: pixels per row per channel; rgb_row_t carries 6 x COLS bits.
- BLANK_CYCLES, 4: cycles OE is deasserted before latch (>=1).
- ON_CYCLES, 256: cycles OE is asserted per row (>=1).

Ports:
- clk_in  in  1  system clock
- n_reset_in  in  1  reset, asynchronous, active-low
- enable_in  in  1  scan enable
- row_ready_out  out  1  request to row fetcher
- row_valid_in  in  1  row data valid, one-cycle pulse
- row_address_in  in  ROW_ADDR_W  row index of delivered data
- row_in  in  rgb_row_t  top/bot red/green/blue, COLS bits each
- hub_r0_out, hub_g0_out, hub_b0_out  out  1 each  top-half serial data
- hub_r1_out, hub_g1_out, hub_b1_out  out  1 each  bottom-half serial data
- hub_clk_out  out  1  panel shift clock
- hub_lat_out  out  1  panel latch
- hub_oe_n_out  out  1  panel output enable, active-low
- hub_addr_out  out  ROW_ADDR_W  panel row select
- frame_done_out  out  1  one-cycle pulse at end of last row's display
- addr_err_out  out  1  sticky row-address mismatch flag

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE and row counter 0. All outputs are 0 except hub_oe_n_out=1. Shift buffer is cleared. Reset mid-operation aborts immediately; there is no partial latch.
- All outputs are registered.
- FSM states: IDLE, REQUEST, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - hub_oe_n_out=1, row_ready_out=0.
  - Goes to REQUEST when enable_in=1.
- REQUEST:
  - row_ready_out=1 until row_valid_in is sampled high.
  - Row data is fetched with variable latency; the FSM waits indefinitely.
  - On row_valid_in=1: capture row_in into the shift buffer. row_ready_out=0 from the next cycle. Go to SHIFT.
  - If row_address_in != row counter, set addr_err_out=1. It stays 1 until reset. The data is still used.
  - row_valid_in outside REQUEST is ignored.
- SHIFT:
  - Columns c = COLS-1 down to 0, two cycles each.
  - Phase 0: data outs = bit c of each channel, hub_clk_out=0.
  - Phase 1: hub_clk_out=1, data held.
  - Channel map: r0=top.red, g0=top.green, b0=top.blue, r1=bot.red, g1=bot.green, b1=bot.blue.
  - Lasts exactly 2*COLS cycles. hub_oe_n_out=1.
  - Goes to BLANK after phase 1 of c=0.
- BLANK:
  - hub_oe_n_out=1, hub_clk_out=0, data outputs 0.
  - hub_addr_out takes the row counter on the first BLANK cycle.
  - Lasts exactly BLANK_CYCLES cycles, then goes to LATCH.
- LATCH:
  - hub_lat_out=1 for exactly one cycle, hub_oe_n_out=1.
  - Then goes to DISPLAY.
- DISPLAY:
  - hub_oe_n_out=0 for exactly ON_CYCLES cycles.
  - On the final cycle, the row counter increments with wrap ROWS-1 -> 0.
  - frame_done_out pulses for one cycle (the cycle after the last display cycle) if the displayed row was ROWS-1.
  - Next state is REQUEST if enable_in=1 on the last display cycle, else IDLE.
- enable_in is sampled only in IDLE and on the last DISPLAY cycle. Deassertion mid-row completes the current row first.
- The row counter is not reset by IDLE; scan resumes at the next row.
- Counters are sized for max(2*COLS, BLANK_CYCLES, ON_CYCLES) with no overflow.
- Row period with zero fetch latency = 1 + 2*COLS + BLANK_CYCLES + 1 + ON_CYCLES cycles.

Test Plan:
1. Reset values: hold n_reset_in=0 with random inputs.
   -> oe_n=1; ready, clk, lat, data, addr, frame_done, addr_err all 0.
   -> Release with enable_in=1 -> row_ready_out=1 next cycle.
2. Single row, defaults:
   - Stimulus: row_valid pulse with row_address_in=0, top.red=64'h8000_0000_0000_0001, others 0.
   - Check: exactly 64 hub_clk_out rising edges; r0=1 on the first and last shifted columns only.
   - Check: 4 blank cycles, hub_addr_out=0, a 1-cycle lat, then oe_n=0 for exactly 256 cycles.
3. Delayed fetch: hold row_valid_in=0 for 37 cycles in REQUEST.
   -> row_ready_out stays 1 for all 37 cycles; no hub_clk_out toggles.
   -> row_ready_out drops the cycle after valid is sampled.
4. Address mismatch: deliver row_address_in=5 while the counter is 0.
   -> addr_err_out=1 and stays 1 across subsequent correct rows until reset.
   -> hub_addr_out=0 for that row.
5. Frame wrap: run 16 rows with matching addresses.
   -> hub_addr_out sequence 0..15, then 0.
   -> frame_done_out is a single 1-cycle pulse after row 15's display, nowhere else.
6. Control disturbances:
   - Drop enable_in during SHIFT of row 3 -> row 3 completes its full display; FSM idles with oe_n=1; re-enable resumes at row 4.
   - Assert n_reset_in=0 mid-SHIFT -> outputs reach reset values immediately, with no lat pulse.
